// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator result BCD conversion path.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_BLANK          = 4'hF;
    localparam logic [3:0] BCD_ADD3_THRESHOLD = 4'd5;

endpackage

// File: rtl/result_bcd_converter_bcd_add3.sv
// Double-dabble digit correction: digits of 5 or more get +3 before the shift.
module bcd_add3
    import calc_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= BCD_ADD3_THRESHOLD) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/result_bcd_converter.sv
// Sequential binary-to-BCD converter for the calculator result bus, one bit per clock.
// Define RESULT_BCD_BLANK_EN to replace leading zero digits with the blank code.
module result_bcd_converter
    import calc_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 5
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [2*WIDTH-1:0]    value_i,
    input  logic                  sign_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  sign_o,
    output logic                  overflow_o
);

    localparam int VW = 2 * WIDTH;
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(VW + 1);

    state_t          state_q, state_d;
    logic [VW-1:0]   shift_q, shift_d;
    logic [BW-1:0]   dig_q, dig_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            sgn_q, sgn_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic            sign_out_q, sign_out_d;
    logic            ovf_out_q, ovf_out_d;

    logic [BW-1:0]   dig_corr;
    logic [BW-1:0]   dig_shift;
    logic [VW-1:0]   sh_shift;
    logic            carry;
    logic [BW-1:0]   bcd_fmt;

    for (genvar i = 0; i < DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_i(dig_q[4*i +: 4]),
            .digit_o(dig_corr[4*i +: 4])
        );
    end

    // Bit leaving the top digit means the value needs more than DIGITS digits.
    assign {carry, dig_shift, sh_shift} = {dig_corr, shift_q, 1'b0};

`ifdef RESULT_BCD_BLANK_EN
    logic lead;
    always_comb begin
        lead    = 1'b1;
        bcd_fmt = dig_shift;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (lead && dig_shift[4*i +: 4] == 4'd0) bcd_fmt[4*i +: 4] = BCD_BLANK;
            else                                     lead = 1'b0;
        end
    end
`else
    assign bcd_fmt = dig_shift;
`endif

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        dig_d      = dig_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        sgn_d      = sgn_q;
        bcd_d      = bcd_q;
        sign_out_d = sign_out_q;
        ovf_out_d  = ovf_out_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = SHIFT;
                    shift_d = value_i;
                    sgn_d   = sign_i;
                    dig_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = CW'(VW);
                end
            end
            SHIFT: begin
                shift_d = sh_shift;
                dig_d   = dig_shift;
                ovf_d   = ovf_q | carry;
                cnt_d   = cnt_q - CW'(1);
                // Final shift: publish the result straight from the shifted value.
                if (cnt_q == CW'(1)) begin
                    state_d    = DONE;
                    bcd_d      = bcd_fmt;
                    sign_out_d = sgn_q;
                    ovf_out_d  = ovf_q | carry;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            dig_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            sgn_q      <= 1'b0;
            bcd_q      <= '0;
            sign_out_q <= 1'b0;
            ovf_out_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            dig_q      <= dig_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            sgn_q      <= sgn_d;
            bcd_q      <= bcd_d;
            sign_out_q <= sign_out_d;
            ovf_out_q  <= ovf_out_d;
        end
    end

    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE);
    assign bcd_o      = bcd_q;
    assign sign_o     = sign_out_q;
    assign overflow_o = ovf_out_q;

endmodule

// File: tb/tb_result_bcd_converter.sv
// Bench for result_bcd_converter: 5-digit and 4-digit instances against a decimal-arithmetic model.
module tb_result_bcd_converter;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       start;
    logic [1:0][15:0] value;
    logic [1:0]       sign;
    logic [1:0][19:0] bcd_w;
    logic [1:0]       busy_w, done_w, sign_w, ovf_w;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Expected display word: value mod 10^d as decimal digits, optionally blanking leading zeros.
    function automatic logic [19:0] exp_bcd(input int v, input int d);
        int p, r, nd;
        logic [19:0] o;
        p = 1;
        for (int i = 0; i < d; i++) p *= 10;
        r  = v % p;
        o  = '0;
        nd = 1;
        for (int t = r / 10; t > 0; t /= 10) nd++;
        for (int i = 0; i < d; i++) begin
            o[4*i +: 4] = 4'(r % 10);
            r /= 10;
`ifdef RESULT_BCD_BLANK_EN
            if (i >= nd) o[4*i +: 4] = 4'hF;
`endif
        end
        return o;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : blk
        localparam int D   = (g == 0) ? 5 : 4;
        localparam int LIM = (g == 0) ? 100000 : 10000;

        logic           busy, done, so, ov;
        logic [4*D-1:0] b;

        result_bcd_converter #(.WIDTH(8), .DIGITS(D)) dut (
            .clock_i   (clk),
            .reset_i   (rst),
            .start_i   (start[g]),
            .value_i   (value[g]),
            .sign_i    (sign[g]),
            .busy_o    (busy),
            .done_o    (done),
            .bcd_o     (b),
            .sign_o    (so),
            .overflow_o(ov)
        );

        assign bcd_w[g]  = 20'(b);
        assign busy_w[g] = busy;
        assign done_w[g] = done;
        assign sign_w[g] = so;
        assign ovf_w[g]  = ov;

        // Timeline model: position within a 17-cycle busy window (0 = idle), result at its end.
        int          m_pos;
        int          m_val;
        logic        m_sg;
        logic [19:0] m_bcd;
        logic        m_sign, m_ovf;

        always @(posedge clk or posedge rst) begin
            if (rst) begin
                m_pos  <= 0;
                m_val  <= 0;
                m_sg   <= 1'b0;
                m_bcd  <= '0;
                m_sign <= 1'b0;
                m_ovf  <= 1'b0;
            end else if (m_pos == 0) begin
                if (start[g]) begin
                    m_pos <= 1;
                    m_val <= int'(value[g]);
                    m_sg  <= sign[g];
                end
            end else if (m_pos == 17) begin
                m_pos <= 0;
            end else begin
                m_pos <= m_pos + 1;
                if (m_pos == 16) begin
                    m_bcd  <= exp_bcd(m_val, D);
                    m_sign <= m_sg;
                    m_ovf  <= (m_val >= LIM);
                end
            end
        end

        always @(negedge clk) begin
            chk((g == 0) ? "d5_busy" : "d4_busy", 32'(busy),     32'(m_pos != 0));
            chk((g == 0) ? "d5_done" : "d4_done", 32'(done),     32'(m_pos == 17));
            chk((g == 0) ? "d5_bcd"  : "d4_bcd",  32'(bcd_w[g]), 32'(m_bcd));
            chk((g == 0) ? "d5_sign" : "d4_sign", 32'(so),       32'(m_sign));
            chk((g == 0) ? "d5_ovf"  : "d4_ovf",  32'(ov),       32'(m_ovf));
        end
    end

    task automatic go(input int g, input logic [15:0] v, input logic s);
        @(posedge clk); #1;
        start[g] = 1'b1; value[g] = v; sign[g] = s;
        @(posedge clk); #1;
        start[g] = 1'b0; value[g] = 16'hFFFF; sign[g] = ~s;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int nb, nd;
        start = '0;
        value = '0;
        sign  = '0;
        idle(3);
        chk("rst_busy", 32'(busy_w[0]), 32'd0);
        chk("rst_bcd",  32'(bcd_w[0]),  32'd0);
        rst = 1'b0;
        idle(2);

        go(0, 16'h0000, 1'b0);
        idle(20);
`ifdef RESULT_BCD_BLANK_EN
        chk("zero_bcd", 32'(bcd_w[0]), 32'h000FFFF0);
`else
        chk("zero_bcd", 32'(bcd_w[0]), 32'h00000000);
`endif
        chk("zero_ovf", 32'(ovf_w[0]), 32'd0);

        go(0, 16'hFE01, 1'b0);
        nb = 0; nd = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy_w[0]) nb++;
            if (done_w[0]) nd++;
        end
        chk("max_busy_len", 32'(nb), 32'd17);
        chk("max_done_cnt", 32'(nd), 32'd1);
        chk("max_bcd", 32'(bcd_w[0]), 32'h00065025);
        chk("max_ovf", 32'(ovf_w[0]), 32'd0);

        go(0, 16'h04D2, 1'b1);
        idle(20);
`ifdef RESULT_BCD_BLANK_EN
        chk("sgn_bcd", 32'(bcd_w[0]), 32'h000F1234);
`else
        chk("sgn_bcd", 32'(bcd_w[0]), 32'h00001234);
`endif
        chk("sgn_sign", 32'(sign_w[0]), 32'd1);

        go(0, 16'h0064, 1'b0);
        idle(4);
        start[0] = 1'b1; value[0] = 16'h0007;
        idle(1);
        start[0] = 1'b0;
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done_w[0]) nd++;
        end
        chk("col_done_cnt", 32'(nd), 32'd1);
`ifdef RESULT_BCD_BLANK_EN
        chk("col_bcd", 32'(bcd_w[0]), 32'h000FF100);
`else
        chk("col_bcd", 32'(bcd_w[0]), 32'h00000100);
`endif
        idle(2);

        go(0, 16'h3039, 1'b0);
        idle(7);
        rst = 1'b1;
        #1;
        chk("rstmid_busy", 32'(busy_w[0]), 32'd0);
        chk("rstmid_bcd",  32'(bcd_w[0]),  32'd0);
        chk("rstmid_done", 32'(done_w[0]), 32'd0);
        idle(1);
        rst = 1'b0;
        idle(1);
        go(0, 16'h3039, 1'b0);
        idle(20);
        chk("fresh_bcd", 32'(bcd_w[0]), 32'h00012345);

        go(1, 16'h2710, 1'b0);
        idle(20);
        chk("d4_10000_ovf", 32'(ovf_w[1]), 32'd1);
`ifdef RESULT_BCD_BLANK_EN
        chk("d4_10000_bcd", 32'(bcd_w[1]), 32'h0000FFF0);
`else
        chk("d4_10000_bcd", 32'(bcd_w[1]), 32'h00000000);
`endif
        go(1, 16'h270F, 1'b0);
        idle(20);
        chk("d4_9999_ovf", 32'(ovf_w[1]), 32'd0);
        chk("d4_9999_bcd", 32'(bcd_w[1]), 32'h00009999);

        start[0] = 1'b1; value[0] = 16'd42; sign[0] = 1'b0;
        idle(40);
        start[0] = 1'b0;
        idle(20);
`ifdef RESULT_BCD_BLANK_EN
        chk("held_bcd", 32'(bcd_w[0]), 32'h000FFF42);
`else
        chk("held_bcd", 32'(bcd_w[0]), 32'h00000042);
`endif

        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
